// File: rtl/mux_etiquetas_rr.sv
// Registered N-channel tag selector with fixed or round-robin channel choice and valid/ready handshakes.
// Optional grant counter output enabled by defining MUX_ETIQUETAS_GRANT_CNT_EN.
module mux_etiquetas_rr #(
   parameter int K    = 8,
   parameter int N    = 4,
   parameter int SELW = $clog2(N)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [N*K-1:0]    IN_DATA,
   input  logic [N-1:0]      IN_VALID,
   output logic [N-1:0]      IN_READY,
   input  logic              MODE,
   input  logic [SELW-1:0]   SEL,
   output logic [K-1:0]      O,
   output logic              O_VALID,
   input  logic              O_READY,
   output logic [SELW-1:0]   O_CH
`ifdef MUX_ETIQUETAS_GRANT_CNT_EN
   ,
   output logic [15:0]       GRANT_CNT
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [K-1:0]      r_o;
   logic [SELW-1:0]   r_ch;
   logic [SELW-1:0]   r_last;
   logic [K-1:0]      w_tag;
   logic [SELW-1:0]   w_win;
   logic              w_has;
   logic              w_load;
   logic              w_xfer;
   logic [2*N-1:0]    w_dbl;
   logic [2*N-1:0]    w_rot;

   // Winner selection: rotating a doubled valid vector puts channel LAST+1 at bit 0.
   always_comb begin
      int idx;
      w_has = 1'b0;
      w_win = '0;
      idx   = 0;
      w_dbl = {IN_VALID, IN_VALID};
      w_rot = w_dbl >> (int'(r_last) + 1);
      if (!MODE) begin
         for (int i = 0; i < N; i++) begin
            if (int'(SEL) == i && IN_VALID[i]) begin
               w_has = 1'b1;
               w_win = SELW'(i);
            end
         end
      end else begin
         for (int j = 0; j < N; j++) begin
            if (!w_has && w_rot[j]) begin
               w_has = 1'b1;
               idx   = (int'(r_last) + 1 + j) % N;
               w_win = idx[SELW-1:0];
            end
         end
      end
   end

   always_comb begin
      w_load = (r_state == EMPTY) || O_READY;
      w_xfer = w_load && w_has && !RST;
      w_tag  = '0;
      for (int i = 0; i < N; i++) begin
         IN_READY[i] = w_xfer && (int'(w_win) == i);
         if (int'(w_win) == i) w_tag = IN_DATA[i*K +: K];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_xfer)                          w_state_nxt = FULL;
      else if (r_state == FULL && O_READY) w_state_nxt = EMPTY;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= EMPTY;
         r_o     <= '0;
         r_ch    <= '0;
         r_last  <= SELW'(N - 1);
      end else begin
         r_state <= w_state_nxt;
         if (w_xfer) begin
            r_o  <= w_tag;
            r_ch <= w_win;
            if (MODE) r_last <= w_win;
         end
      end
   end

`ifdef MUX_ETIQUETAS_GRANT_CNT_EN
   logic [15:0] r_grant_cnt;

   always_ff @(posedge CLK) begin
      if (RST)
         r_grant_cnt <= '0;
      else if (r_state == FULL && O_READY && r_grant_cnt != 16'hFFFF)
         r_grant_cnt <= r_grant_cnt + 16'd1;
   end

   assign GRANT_CNT = r_grant_cnt;
`endif

   assign O       = r_o;
   assign O_CH    = r_ch;
   assign O_VALID = (r_state == FULL);

endmodule

// File: doc/mux_etiquetas_rr.md
Name: mux_etiquetas_rr

Overview:
- Registered N-channel, K-bit tag selector with a valid/ready handshake on every input channel and on the output.
- Two selection modes:
  - fixed: channel chosen by SEL
  - round-robin: fair arbitration among valid channels
- Sits between tag sources (cache tag arrays, miss queues) and the tag comparator.
- Holds the selected tag and its channel index stable until the consumer accepts it.

Parameters:
- K, 8, width of each tag channel in bits
- N, 4, number of input channels (2..16)
- SELW, $clog2(N), width of SEL and O_CH (derived; not to be overridden)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  synchronous, active-high reset
- IN_DATA  input  N*K  packed channel tags; channel i occupies bits [i*K +: K]
- IN_VALID  input  N  per-channel valid
- IN_READY  output  N  per-channel ready (one-hot or zero)
- MODE  input  1  0 = fixed select via SEL, 1 = round-robin
- SEL  input  SELW  channel index used in fixed mode
- O  output  K  registered selected tag
- O_VALID  output  1  O and O_CH hold valid data
- O_READY  input  1  consumer accepts O this cycle
- O_CH  output  SELW  index of the channel whose tag is in O

Behaviour:
- Reset (RST=1 at a rising edge):
  - O=0, O_VALID=0, O_CH=0
  - round-robin pointer LAST=N-1, so channel 0 has top priority after reset
  - held data is discarded; no IN_READY is asserted during the reset cycle
- States:
  - EMPTY (O_VALID=0)
  - FULL (O_VALID=1)
- load = EMPTY, or (FULL and O_READY).
- Candidate set:
  - MODE=0: only channel SEL, and only if SEL<N and IN_VALID[SEL]=1; SEL>=N gives no candidate and never grants
  - MODE=1: all i with IN_VALID[i]=1
- Winner in MODE=1: first candidate scanning LAST+1, LAST+2, ... modulo N (wraps N-1 -> 0).
- IN_READY is combinational:
  - IN_READY[winner]=1 only when load=1 and a candidate exists
  - all other bits 0; never more than one bit set
- Transfer on a channel: IN_VALID[i] and IN_READY[i] high at the same edge. At that edge:
  - O <= tag of channel i
  - O_CH <= i
  - O_VALID <= 1
  - in MODE=1 only: LAST <= i
- Output handshake: O_VALID and O_READY high at the same edge. At that edge:
  - if a new input transfer happens in the same cycle, the register reloads with the new tag (back-to-back, full throughput, 1 transfer/cycle)
  - otherwise O_VALID <= 0; O and O_CH keep their last value
- Latency: input accepted at edge t appears on O/O_VALID immediately after edge t (1 cycle).
- While FULL and O_READY=0:
  - O, O_CH, O_VALID are stable
  - IN_READY=0 for all channels
- MODE or SEL changes:
  - take effect at the next load decision
  - never alter held data
  - LAST is preserved across mode changes and updates only on MODE=1 grants
- Inputs with IN_VALID=0 are ignored regardless of IN_DATA.
- N=1 is out of range (the design targets N>=2); behaviour is unspecified.

Optional Feature:
- Macro: MUX_ETIQUETAS_GRANT_CNT_EN.
- When defined:
  - extra output port GRANT_CNT, output, 16 bits
  - counts output handshakes (O_VALID and O_READY at the same edge)
  - saturates at 16'hFFFF
  - cleared to 0 by RST
- When undefined:
  - port and counter absent
  - all other behaviour identical

Test Plan:
1. Reset check: RST=1 for 2 cycles with all IN_VALID=1 -> O=0, O_VALID=0, O_CH=0, IN_READY=0000 throughout; after release, first grant goes to channel 0.
2. Round-robin fairness: K=8, N=4, MODE=1, IN_VALID=1111, IN_DATA={8'h44,8'h33,8'h22,8'h11}, O_READY=1 -> O sequence 11,22,33,44,11 on consecutive cycles with O_CH 0,1,2,3,0 and O_VALID held at 1.
3. Backpressure: FULL with O=8'h22, O_READY=0 for 3 cycles while IN_VALID=1111 -> O, O_CH and O_VALID unchanged and IN_READY=0000 for all 3 cycles; on O_READY=1, the next channel (2, value 8'h33) loads in the same cycle.
4. Fixed mode and out-of-range select: MODE=0, SEL=2, IN_VALID=0100, IN_DATA ch2=8'hA5 -> O=A5, O_CH=2. Then SEL=3 with IN_VALID[3]=0 -> no grant and O_VALID drops after the handshake. With N=3 and SEL=3 -> never any IN_READY.
5. Wrap and skip: MODE=1, LAST=2, IN_VALID=0011 -> grant ch0 then ch1; sparse IN_VALID=1001 -> alternating 0,3,0,3.
6. Reset mid-operation and counter: FULL and stalled with O=8'h77 when RST is pulsed -> O_VALID=0 and O=0 the next cycle. With MUX_ETIQUETAS_GRANT_CNT_EN defined, 5 output handshakes -> GRANT_CNT=5, and GRANT_CNT=0 after RST.
